alu_seq: RTL

//   Next-generation execute-stage ALU: registered, handshake-driven, width-parametrised.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshake on both sides.
// Define ALU_MULDIV_EN to build the iterative 1-bit/cycle multiply/divide unit.
module alu_seq #(
    parameter int D_WIDTH = 32,
    parameter int OP_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_SIZE-1:0] alu_op,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] y,
    output logic               zero,
    output logic               busy
);
    localparam int SW = $clog2(D_WIDTH);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic {IDLE, DONE} state_t;
`endif

    state_t             state_q;
    logic [D_WIDTH-1:0] y_q;
    logic               zero_q;
    logic [SW-1:0]      shamt;
    logic [D_WIDTH-1:0] alu_res;

    always_comb begin
        shamt   = b[SW-1:0];
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = {{(D_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd6:    alu_res = a << shamt;
            4'd7:    alu_res = a >> shamt;
            4'd14:   alu_res = $signed(a) >>> shamt;
            4'd15:   alu_res = {{(D_WIDTH-1){1'b0}}, a < b};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [SW-1:0] LAST = SW'(D_WIDTH - 1);

    logic [OP_SIZE-1:0] op_q;
    logic [D_WIDTH-1:0] d_q, hi_q, lo_q;
    logic [D_WIDTH-1:0] hi_d, lo_d, md_res;
    logic [D_WIDTH-1:0] a_mag, b_mag;
    logic [SW-1:0]      cnt_q;
    logic               negq_q, negr_q;
    logic               is_md, is_mul, sgn, a_neg, b_neg;
    logic [D_WIDTH:0]   sum, rsh, diff;

    always_comb begin
        is_md  = (alu_op >= 4'd8) && (alu_op <= 4'd13);
        is_mul = (alu_op == 4'd8) || (alu_op == 4'd9);
        sgn    = (alu_op == 4'd10) || (alu_op == 4'd12);
        a_neg  = sgn & a[D_WIDTH-1];
        b_neg  = sgn & b[D_WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // mul: {hi,lo} is a shift-add product; div: hi=remainder, lo=dividend/quotient
    always_comb begin
        sum  = '0;
        rsh  = '0;
        diff = '0;
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q == 4'd8 || op_q == 4'd9) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
            hi_d = sum[D_WIDTH:1];
            lo_d = {sum[0], lo_q[D_WIDTH-1:1]};
        end else begin
            rsh  = {hi_q, lo_q[D_WIDTH-1]};
            diff = rsh - {1'b0, d_q};
            if (diff[D_WIDTH]) begin
                hi_d = rsh[D_WIDTH-1:0];
                lo_d = {lo_q[D_WIDTH-2:0], 1'b0};
            end else begin
                hi_d = diff[D_WIDTH-1:0];
                lo_d = {lo_q[D_WIDTH-2:0], 1'b1};
            end
        end
        case (op_q)
            4'd8:         md_res = lo_d;
            4'd9:         md_res = hi_d;
            4'd10, 4'd11: md_res = negq_q ? -lo_d : lo_d;
            4'd12, 4'd13: md_res = negr_q ? -hi_d : hi_d;
            default:      md_res = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            zero_q  <= 1'b1;
`ifdef ALU_MULDIV_EN
            op_q    <= '0;
            d_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MULDIV_EN
                        if (is_md) begin
                            state_q <= BUSY;
                            op_q    <= alu_op;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            d_q     <= is_mul ? a : b_mag;
                            lo_q    <= is_mul ? b : a_mag;
                            // divide-by-zero keeps the raw all-ones quotient
                            negq_q  <= (a_neg ^ b_neg) & (b != '0);
                            negr_q  <= a_neg;
                        end else begin
                            state_q <= DONE;
                            y_q     <= alu_res;
                            zero_q  <= (alu_res == '0);
                        end
`else
                        state_q <= DONE;
                        y_q     <= alu_res;
                        zero_q  <= (alu_res == '0);
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        y_q     <= md_res;
                        zero_q  <= (md_res == '0);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign zero      = zero_q;
`ifdef ALU_MULDIV_EN
    assign busy      = (state_q == BUSY);
`else
    assign busy      = 1'b0;
`endif

endmodule
